// File: rtl/killer_update_sched.sv
// Schedules killer-table update and clear pulses towards the killer evaluator.
// A grant holds ply/board on the evaluator bus for SETUP_CYCLES cycles before a one-cycle pulse.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module killer_update_sched #(
    parameter int MAX_DEPTH_LOG2 = 0,
    parameter int SETUP_CYCLES   = 2,
    parameter int GAP_CYCLES     = 1,
    localparam int PLY_W         = (MAX_DEPTH_LOG2 > 0) ? MAX_DEPTH_LOG2 : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    eval_busy,
    input  logic                    clear_req,
    output logic                    clear_ack,
    input  logic                    req0_valid,
    input  logic [PLY_W-1:0]        req0_ply,
    input  logic [`BOARD_WIDTH-1:0] req0_board,
    output logic                    req0_ack,
    input  logic                    req1_valid,
    input  logic [PLY_W-1:0]        req1_ply,
    input  logic [`BOARD_WIDTH-1:0] req1_board,
    output logic                    req1_ack,
    output logic [PLY_W-1:0]        killer_ply,
    output logic [`BOARD_WIDTH-1:0] killer_board,
    output logic                    killer_update,
    output logic                    killer_clear,
    output logic                    busy,
    output logic [2:0]              fsm_state
);

    typedef enum logic [2:0] {IDLE, SETUP, UPD, CLR, GAP} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       rr_ptr, rr_nxt;  // 0: req0 wins a tie, 1: req1 wins a tie

    // Handshake: a requester raises valid with stable data and holds both until
    // it sees its one-cycle ack; data is captured on the ack cycle. Acks are
    // only ever issued from IDLE, out of reset, while the evaluator is free.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rr_nxt    = rr_ptr;
        clear_ack = 1'b0;
        req0_ack  = 1'b0;
        req1_ack  = 1'b0;
        case (state)
            IDLE: begin
                if (reset && !eval_busy) begin
                    if (clear_req) begin
                        clear_ack = 1'b1;
                        state_nxt = CLR;
                    end else if (req0_valid && (!req1_valid || !rr_ptr)) begin
                        req0_ack  = 1'b1;
                        rr_nxt    = 1'b1;
                        state_nxt = SETUP;
                        cnt_nxt   = 4'(SETUP_CYCLES - 1);
                    end else if (req1_valid) begin
                        req1_ack  = 1'b1;
                        rr_nxt    = 1'b0;
                        state_nxt = SETUP;
                        cnt_nxt   = 4'(SETUP_CYCLES - 1);
                    end
                end
            end
            SETUP: begin
                if (cnt == 4'd0) state_nxt = UPD;
                else             cnt_nxt   = cnt - 4'd1;
            end
            UPD, CLR: begin
                state_nxt = GAP;
                cnt_nxt   = 4'(GAP_CYCLES - 1);
            end
            GAP: begin
                if (cnt == 4'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            rr_ptr       <= 1'b0;
            killer_ply   <= '0;
            killer_board <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rr_ptr <= rr_nxt;
            // Evaluator bus only moves on an update grant; clears leave it alone.
            if (req0_ack) begin
                killer_ply   <= req0_ply;
                killer_board <= req0_board;
            end else if (req1_ack) begin
                killer_ply   <= req1_ply;
                killer_board <= req1_board;
            end
        end
    end

    assign killer_update = (state == UPD);
    assign killer_clear  = (state == CLR);
    assign busy          = (state != IDLE);
    assign fsm_state     = state;

endmodule

// File: doc/killer_update_sched.md
KILLER_UPDATE_SCHED -- requirements
Module: killer_update_sched

Interface
REQ-001 SHALL have parameter MAX_DEPTH_LOG2, default 0 (must be overridden), width of ply fields.
REQ-002 SHALL have parameter SETUP_CYCLES, default 2, cycles killer_ply is held stable before the update pulse (range 1..15).
REQ-003 SHALL have parameter GAP_CYCLES, default 1, idle cycles after any pulse before the next grant (range 1..15).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port eval_busy  input  1  evaluator lookup in flight; blocks new grants.
REQ-007 SHALL have port clear_req  input  1  request to invalidate the whole killer table; held until clear_ack.
REQ-008 SHALL have port clear_ack  output  1  one-cycle grant of clear_req.
REQ-009 SHALL have ports req0_valid / req1_valid  input  1  update request from requester 0 / 1; held until the matching ack.
REQ-010 SHALL have ports req0_ply / req1_ply  input  MAX_DEPTH_LOG2  target ply.
REQ-011 SHALL have ports req0_board / req1_board  input  `BOARD_WIDTH  killer board to insert.
REQ-012 SHALL have ports req0_ack / req1_ack  output  1  one-cycle grant; data sampled this cycle.
REQ-013 SHALL have port killer_ply  output  MAX_DEPTH_LOG2  ply driven to the killer evaluator.
REQ-014 SHALL have port killer_board  output  `BOARD_WIDTH  board driven to the killer evaluator.
REQ-015 SHALL have ports killer_update / killer_clear  output  1  single-cycle pulses to the evaluator.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, SETUP, UPD, CLR, GAP.
REQ-018 In IDLE with eval_busy low: clear_req SHALL have priority over both update requests.
REQ-019 In IDLE with eval_busy high: no grant; requests wait; no outputs change.
REQ-020 Between update requests, arbitration SHALL be round-robin: when both are valid, grant the one not granted last; pointer favours req0 after reset; a single valid request is granted immediately.
REQ-021 On update grant at cycle T: reqN_ack=1 at T; killer_ply/killer_board load the requester's values at T+1; state SETUP for SETUP_CYCLES cycles (T+1..T+SETUP_CYCLES).
REQ-022 UPD SHALL last exactly one cycle with killer_update=1 (T+SETUP_CYCLES+1), then enter GAP.
REQ-023 On clear grant at T: clear_ack=1 at T; killer_clear=1 at T+1 (state CLR, one cycle), then GAP.
REQ-024 GAP SHALL last GAP_CYCLES cycles with killer_update=killer_clear=0, then IDLE; earliest next grant is the first IDLE cycle.
REQ-025 killer_ply/killer_board SHALL hold their last loaded value in all states until the next update grant; a clear SHALL NOT alter them.
REQ-026 Acks SHALL NOT be issued outside IDLE; at most one ack per cycle.
REQ-027 eval_busy rising after a grant SHALL NOT abort or stretch the sequence; the evaluator owner must not start a lookup while busy=1.
REQ-028 killer_update and killer_clear SHALL never be high in the same cycle, nor in consecutive cycles.
REQ-029 Defaults give update occupancy of 5 cycles (grant to next possible grant) and clear occupancy of 3.

Reset
REQ-030 While reset=0 at a posedge: state IDLE, all acks/pulses/busy=0, killer_ply=0, killer_board=0, arbitration pointer favours req0.
REQ-031 Reset mid-sequence SHALL abandon the sequence without issuing a pending pulse; already-acked requests are lost.

Verification
REQ-032 Single update: req0_valid, ply=5, board=B1 at T -> req0_ack at T, killer_ply=5 at T+1, killer_update only at T+3, busy T+1..T+4, IDLE at T+5.
REQ-033 Contention: req0 and req1 valid continuously -> acks alternate req0, req1, req0 at 5-cycle spacing; killer_ply tracks each granted ply.
REQ-034 Priority: clear_req with both reqs valid -> clear_ack first, killer_clear at T+1, next grant at T+3 goes to req0.
REQ-035 Blocking: eval_busy=1 for 10 cycles with req1 valid -> no ack until first cycle eval_busy=0, then normal sequence.
REQ-036 Reset: assert reset=0 in SETUP -> next cycle busy=0, killer_ply=0, no killer_update pulse thereafter.
REQ-037 Checker throughout: single-cycle pulses, no update/clear adjacency, killer_ply stable SETUP_CYCLES cycles before each killer_update.
